i2c_master_byte_ctrl: RTL

Byte-level I2C master sequencer that sits directly upstream of the I2C bus interface (SCL generator / open-drain driver / input synchroniser). It accepts WRITE, READ and STOP commands through a valid/ready handshake and drives the interface's i2c_clk_en, sda_out_en and sda_data_out. It consumes the interface's scl_i, sda_i and scl_pulse (SCL falling edge) to generate START, 8 data bits plus ACK/NACK, and STOP. It returns received bytes and ACK status. Single master only: no clock stretching, no arbitration.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_hold_timer.sv | 32 +++
 rtl/i2c_master_byte_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared op codes, sequencer states and SCL timing helper
package i2c_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_STOP  = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START_HOLD,
      ST_DATA,
      ST_STOP_LOW,
      ST_STOP_HOLD
   } state_e;

   // Clock cycles per SCL half period; the bus interface uses the same value.
   function automatic int half_cycles(input int clk_hz, input int i2c_hz);
      return (clk_hz / i2c_hz) / 2;
   endfunction

endpackage

// File: rtl/i2c_hold_timer.sv
// rtl/i2c_hold_timer.sv - HALF-cycle hold timer for START/STOP phases
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : (re)start a hold of HALF cycles
//   done_o       : high in the last cycle of the hold; the owner leaves its state on that edge
module i2c_hold_timer #(
   parameter int HALF = 5
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   output logic done_o
);

   localparam int W = $clog2(HALF + 1);

   logic [W-1:0] cnt_q;

   // Counts down and parks at zero, so a stale timer never re-fires.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= W'(HALF);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// rtl/i2c_master_byte_ctrl.sv - byte-level I2C master sequencer (START, 8 bits + ACK, STOP)
// Ports:
//   clk, rst                            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_nack : command handshake (WRITE, READ, STOP)
//   rsp_valid/rsp_data/rsp_ack          : per-byte result pulse
//   busy, underrun                      : status
//   i2c_clk_en/sda_out_en/sda_data_out  : controls to the bus interface
//   scl_i/sda_i/scl_pulse               : synchronised lines and SCL falling strobe
module i2c_master_byte_ctrl
   import i2c_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 500_000_000,
   parameter int I2C_FREQ_HZ = 100_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   input  logic       cmd_nack,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_ack,
   output logic       busy,
   output logic       underrun,
   output logic       i2c_clk_en,
   output logic       sda_out_en,
   output logic       sda_data_out,
   input  logic       scl_i,
   input  logic       sda_i,
   input  logic       scl_pulse
);

   localparam int HALF = half_cycles(CLK_FREQ_HZ, I2C_FREQ_HZ);

   state_e     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   op_e        op_q, op_d;
   logic [7:0] data_q, data_d;
   logic       nack_q, nack_d;
   logic       pend_q, pend_d;
   op_e        pend_op_q, pend_op_d;
   logic [7:0] pend_data_q, pend_data_d;
   logic       pend_nack_q, pend_nack_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_ack_q, rsp_ack_d;
   logic       underrun_q, underrun_d;
   logic       clk_en_q, clk_en_d;
   logic       sda_oe_q, sda_oe_d;
   logic       sda_do_q, sda_do_d;
   logic       scl_q;
   logic       timer_load, timer_done;
   logic       scl_rise, cmd_fire, go;
   op_e        cmd_op_e, src_op;
   logic [7:0] src_data;
   logic       src_nack;

   i2c_hold_timer #(.HALF(HALF)) u_hold (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (timer_load),
      .done_o (timer_done)
   );

   assign scl_rise  = scl_i & ~scl_q;
   assign cmd_ready = ((state_q == ST_IDLE) || (state_q == ST_DATA)) && !pend_q;
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign cmd_op_e  = op_e'(cmd_op);

   // A command left in the slot when the bus went idle (filled on the same
   // edge an underrun fired) is launched before any new command.
   assign go       = pend_q || cmd_fire;
   assign src_op   = pend_q ? pend_op_q   : cmd_op_e;
   assign src_data = pend_q ? pend_data_q : cmd_data;
   assign src_nack = pend_q ? pend_nack_q : cmd_nack;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      op_d        = op_q;
      data_d      = data_q;
      nack_d      = nack_q;
      pend_d      = pend_q;
      pend_op_d   = pend_op_q;
      pend_data_d = pend_data_q;
      pend_nack_d = pend_nack_q;
      shreg_d     = shreg_q;
      rsp_data_d  = rsp_data_q;
      rsp_ack_d   = rsp_ack_q;
      rsp_valid_d = 1'b0;
      underrun_d  = 1'b0;
      clk_en_d    = clk_en_q;
      sda_oe_d    = sda_oe_q;
      sda_do_d    = sda_do_q;
      timer_load  = 1'b0;

      // Slot fill happens before consumption below, so consumption sees the old slot.
      if (state_q == ST_DATA && cmd_fire && cmd_op_e != OP_RSVD) begin
         pend_d      = 1'b1;
         pend_op_d   = cmd_op_e;
         pend_data_d = cmd_data;
         pend_nack_d = cmd_nack;
      end

      case (state_q)
         ST_IDLE: begin
            if (go) begin
               pend_d = 1'b0;
               if (src_op == OP_WRITE || src_op == OP_READ) begin
                  op_d       = src_op;
                  data_d     = src_data;
                  nack_d     = src_nack;
                  sda_oe_d   = 1'b1;
                  sda_do_d   = 1'b0;
                  timer_load = 1'b1;
                  state_d    = ST_START_HOLD;
               end
            end
         end

         ST_START_HOLD: begin
            if (timer_done) begin
               clk_en_d  = 1'b1;
               bit_cnt_d = 4'd0;
               state_d   = ST_DATA;
            end
         end

         ST_DATA: begin
            // bit_cnt has already advanced past the slot whose rising edge this is.
            if (scl_rise) begin
               if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd8) begin
                  shreg_d = {shreg_q[6:0], sda_i};
               end else if (bit_cnt_q == 4'd9) begin
                  rsp_ack_d = sda_i;
               end
            end
            if (scl_pulse) begin
               if (bit_cnt_q < 4'd8) begin
                  sda_do_d  = (op_q == OP_WRITE) ? data_q[3'd7 - bit_cnt_q[2:0]] : 1'b1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (bit_cnt_q == 4'd8) begin
                  sda_do_d  = (op_q == OP_WRITE) ? 1'b1 : nack_q;
                  bit_cnt_d = 4'd9;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = shreg_q;
                  if (pend_q && (pend_op_q == OP_WRITE || pend_op_q == OP_READ)) begin
                     op_d      = pend_op_q;
                     data_d    = pend_data_q;
                     nack_d    = pend_nack_q;
                     pend_d    = 1'b0;
                     sda_do_d  = (pend_op_q == OP_WRITE) ? pend_data_q[7] : 1'b1;
                     bit_cnt_d = 4'd1;
                  end else begin
                     if (pend_q) begin
                        pend_d = 1'b0;
                     end else begin
                        underrun_d = 1'b1;
                     end
                     sda_do_d   = 1'b0;
                     timer_load = 1'b1;
                     state_d    = ST_STOP_LOW;
                  end
               end
            end
         end

         ST_STOP_LOW: begin
            if (timer_done) begin
               clk_en_d   = 1'b0;
               timer_load = 1'b1;
               state_d    = ST_STOP_HOLD;
            end
         end

         ST_STOP_HOLD: begin
            if (timer_done) begin
               sda_oe_d = 1'b0;
               sda_do_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 4'd0;
         op_q        <= OP_WRITE;
         data_q      <= 8'd0;
         nack_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_op_q   <= OP_WRITE;
         pend_data_q <= 8'd0;
         pend_nack_q <= 1'b0;
         shreg_q     <= 8'd0;
         rsp_data_q  <= 8'd0;
         rsp_valid_q <= 1'b0;
         rsp_ack_q   <= 1'b1;
         underrun_q  <= 1'b0;
         clk_en_q    <= 1'b0;
         sda_oe_q    <= 1'b0;
         sda_do_q    <= 1'b1;
         scl_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         op_q        <= op_d;
         data_q      <= data_d;
         nack_q      <= nack_d;
         pend_q      <= pend_d;
         pend_op_q   <= pend_op_d;
         pend_data_q <= pend_data_d;
         pend_nack_q <= pend_nack_d;
         shreg_q     <= shreg_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ack_q   <= rsp_ack_d;
         underrun_q  <= underrun_d;
         clk_en_q    <= clk_en_d;
         sda_oe_q    <= sda_oe_d;
         sda_do_q    <= sda_do_d;
         scl_q       <= scl_i;
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_ack      = rsp_ack_q;
   assign underrun     = underrun_q;
   assign busy         = (state_q != ST_IDLE);
   assign i2c_clk_en   = clk_en_q;
   assign sda_out_en   = sda_oe_q;
   assign sda_data_out = sda_do_q;

endmodule
